cart_led_sequencer: RTL and testbench

//  Owns the single cart status LED and shares it between three requesters: bus/storage activity

---
 rtl/cart_led_pkg.sv | 30 +++
 rtl/cart_led_prescaler.sv | 36 +++
 rtl/cart_led_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cart_led_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_led_pkg.sv
// cart_led_pkg: shared types and default timing constants for the cart LED sequencer.
//   err_state_e : error blink FSM states (IDLE / ON / OFF / GAP)
//   err_code_t  : 4-bit blink count (1..15, 0 means "clear")
//   DEF_*       : default tick counts used as parameter defaults by the top
//   max3        : helper for sizing the shared phase counter
package cart_led_pkg;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ON   = 2'd1,
    ERR_OFF  = 2'd2,
    ERR_GAP  = 2'd3
  } err_state_e;

  typedef logic [3:0] err_code_t;

  localparam int DEF_NUM_SOURCES     = 4;
  localparam int DEF_PRESCALER_DIV   = 1000000;
  localparam int DEF_ACTIVITY_TICKS  = 3;
  localparam int DEF_BLINK_ON_TICKS  = 20;
  localparam int DEF_BLINK_OFF_TICKS = 20;
  localparam int DEF_GAP_TICKS       = 100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cart_led_prescaler.sv
// cart_led_prescaler: free-running tick generator for the LED timebase.
//   i_clk, i_reset : clock, synchronous active-high reset (count returns to 0)
//   i_restart      : force the count back to 0 on the next edge
//   o_tick         : high for one cycle while the count sits at PRESCALER_DIV-1
module cart_led_prescaler #(
  parameter int PRESCALER_DIV = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = $clog2(PRESCALER_DIV);
  localparam logic [CW-1:0] TERM = CW'(PRESCALER_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_restart || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == TERM);

endmodule

// File: rtl/cart_led_sequencer.sv
// cart_led_sequencer: owns the cart status LED and arbitrates between activity
// pulses, a repeating error blink code and a CPU override.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_activity         : activity triggers, any bit high (re)starts the stretch
//   i_error_valid      : strobe, load i_error_code (0 clears the pattern)
//   i_error_code       : blink count 1..15
//   i_error_clear      : strobe, stop the error pattern (wins over i_error_valid)
//   i_override_en      : CPU forces the LED (only when CART_LED_OVERRIDE_EN is defined)
//   i_override_value   : forced LED level
//   o_led              : registered LED drive
//   o_error_active     : registered, high while an error pattern runs
// Build option: define CART_LED_OVERRIDE_EN to honour the override inputs; otherwise
// they are accepted but ignored and the error pattern has top priority.
module cart_led_sequencer
  import cart_led_pkg::*;
#(
  parameter int NUM_SOURCES     = DEF_NUM_SOURCES,
  parameter int PRESCALER_DIV   = DEF_PRESCALER_DIV,
  parameter int ACTIVITY_TICKS  = DEF_ACTIVITY_TICKS,
  parameter int BLINK_ON_TICKS  = DEF_BLINK_ON_TICKS,
  parameter int BLINK_OFF_TICKS = DEF_BLINK_OFF_TICKS,
  parameter int GAP_TICKS       = DEF_GAP_TICKS
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_SOURCES-1:0] i_activity,
  input  logic                   i_error_valid,
  input  logic [3:0]             i_error_code,
  input  logic                   i_error_clear,
  input  logic                   i_override_en,
  input  logic                   i_override_value,
  output logic                   o_led,
  output logic                   o_error_active
);

  localparam int PW = $clog2(max3(BLINK_ON_TICKS, BLINK_OFF_TICKS, GAP_TICKS) + 1);
  localparam int AW = $clog2(ACTIVITY_TICKS + 1);

  localparam logic [PW-1:0] ON_LAST    = PW'(BLINK_ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST   = PW'(BLINK_OFF_TICKS - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_TICKS - 1);
  localparam logic [AW-1:0] ACT_RELOAD = AW'(ACTIVITY_TICKS);

  err_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  err_code_t     blink_q, blink_d;
  err_code_t     code_q, code_d;
  err_code_t     blink_inc;
  logic [AW-1:0] act_q, act_d;
  logic          led_q, led_d;
  logic          active_q, active_d;
  logic          tick;
  logic          restart;
  logic          err_load;
  logic          err_stop;

  cart_led_prescaler #(
    .PRESCALER_DIV (PRESCALER_DIV)
  ) u_prescaler (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (restart),
    .o_tick    (tick)
  );

  // Clear (explicit or via a zero code) takes precedence over a new load.
  assign err_stop  = i_error_clear || (i_error_valid && (i_error_code == 4'd0));
  assign err_load  = i_error_valid && (i_error_code != 4'd0) && !i_error_clear;
  assign restart   = err_load;
  assign blink_inc = blink_q + 4'd1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    blink_d = blink_q;
    code_d  = code_q;
    if (err_stop) begin
      state_d = ERR_IDLE;
      phase_d = '0;
      blink_d = '0;
    end else if (err_load) begin
      // A load in any state restarts the code from its first ON phase.
      state_d = ERR_ON;
      phase_d = '0;
      blink_d = '0;
      code_d  = i_error_code;
    end else if (tick) begin
      case (state_q)
        ERR_ON: begin
          if (phase_q == ON_LAST) begin
            phase_d = '0;
            blink_d = blink_inc;
            state_d = (blink_inc == code_q) ? ERR_GAP : ERR_OFF;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        ERR_OFF: begin
          if (phase_q == OFF_LAST) begin
            phase_d = '0;
            state_d = ERR_ON;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        ERR_GAP: begin
          if (phase_q == GAP_LAST) begin
            phase_d = '0;
            blink_d = '0;
            state_d = ERR_ON;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: begin
          state_d = ERR_IDLE;
        end
      endcase
    end
  end

  // Retriggerable activity stretch; keeps counting even while masked by an error.
  always_comb begin
    act_d = act_q;
    if (|i_activity) begin
      act_d = ACT_RELOAD;
    end else if (tick && (act_q != '0)) begin
      act_d = act_q - 1'b1;
    end
  end

  // Outputs are derived from next-state values so any input reaches the pin
  // on the very next edge.
  always_comb begin
    active_d = (state_d != ERR_IDLE);
    if (active_d) begin
      led_d = (state_d == ERR_ON);
    end else begin
      led_d = (act_d != '0);
    end
`ifdef CART_LED_OVERRIDE_EN
    if (i_override_en) begin
      led_d = i_override_value;
    end
`endif
  end

`ifndef CART_LED_OVERRIDE_EN
  logic unused_override;
  assign unused_override = i_override_en ^ i_override_value;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ERR_IDLE;
      phase_q  <= '0;
      blink_q  <= '0;
      code_q   <= '0;
      act_q    <= '0;
      led_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
      code_q   <= code_d;
      act_q    <= act_d;
      led_q    <= led_d;
      active_q <= active_d;
    end
  end

  assign o_led          = led_q;
  assign o_error_active = active_q;

endmodule

// File: tb/tb_cart_led_sequencer.sv
// tb_cart_led_sequencer: self-checking bench for cart_led_sequencer with a short
// timebase (DIV=4, ACTIVITY=2, ON=2, OFF=2, GAP=4 ticks => 8/8/16 cycle phases).
module tb_cart_led_sequencer;

  logic       clk;
  logic       i_reset;
  logic [3:0] i_activity;
  logic       i_error_valid;
  logic [3:0] i_error_code;
  logic       i_error_clear;
  logic       i_override_en;
  logic       i_override_value;
  logic       o_led;
  logic       o_error_active;

  int vectors;
  int miscompares;

  // Expected {o_error_active, o_led} per checked cycle.
  logic [1:0] exp_q[$];

  cart_led_sequencer #(
    .NUM_SOURCES     (4),
    .PRESCALER_DIV   (4),
    .ACTIVITY_TICKS  (2),
    .BLINK_ON_TICKS  (2),
    .BLINK_OFF_TICKS (2),
    .GAP_TICKS       (4)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_activity       (i_activity),
    .i_error_valid    (i_error_valid),
    .i_error_code     (i_error_code),
    .i_error_clear    (i_error_clear),
    .i_override_en    (i_override_en),
    .i_override_value (i_override_value),
    .o_led            (o_led),
    .o_error_active   (o_error_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected waveform of a running code: ON 8, then OFF 8 between blinks, GAP 16 after the last.
  task automatic push_code(input int code, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int b = 1; b <= code; b++) begin
        for (int i = 0; i < 8; i++) exp_q.push_back(2'b11);
        for (int i = 0; i < ((b < code) ? 8 : 16); i++) exp_q.push_back(2'b10);
      end
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    i_reset = 1'b1;
    repeat (3) step();
    exp_q.push_back(2'b00);
    exp = exp_q.pop_front();
    vectors++;
    if ({o_error_active, o_led} !== exp) begin
      miscompares++;
      $display("FAIL reset_state: got active/led=%b want %b", {o_error_active, o_led}, exp);
    end
    i_reset = 1'b0;
    for (int i = 0; i < 100; i++) exp_q.push_back(2'b00);
    for (int i = 0; i < 100; i++) begin
      step();
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: got active/led=%b want %b", i, {o_error_active, o_led}, exp);
      end
    end
  endtask

  task automatic test_activity();
    int len;
    // Single pulse on bit 2.
    i_activity = 4'b0100;
    step();
    i_activity = 4'b0000;
    vectors++;
    if (o_led !== 1'b1) begin
      miscompares++;
      $display("FAIL activity_first: got led=%b want 1", o_led);
    end
    len = 1;
    while (o_led === 1'b1 && len < 20) begin
      step();
      if (o_led === 1'b1) len++;
    end
    vectors++;
    if (len < 5 || len > 8) begin
      miscompares++;
      $display("FAIL activity_stretch: got %0d lit cycles want 5..8", len);
    end
    repeat (12) step();
    vectors++;
    if (o_led !== 1'b0) begin
      miscompares++;
      $display("FAIL activity_settle: got led=%b want 0", o_led);
    end
    // Retrigger while lit: second pulse reloads the full window.
    i_activity = 4'b0100;
    step();
    i_activity = 4'b0000;
    repeat (2) begin
      vectors++;
      if (o_led !== 1'b1) begin
        miscompares++;
        $display("FAIL retrigger_lit: got led=%b want 1", o_led);
      end
      step();
    end
    i_activity = 4'b0001;
    step();
    i_activity = 4'b0000;
    len = 1;
    while (o_led === 1'b1 && len < 20) begin
      step();
      if (o_led === 1'b1) len++;
    end
    vectors++;
    if (len < 5 || len > 8) begin
      miscompares++;
      $display("FAIL retrigger_stretch: got %0d lit cycles after reload want 5..8", len);
    end
    repeat (12) step();
  endtask

  task automatic test_error_pattern();
    logic [1:0] exp;
    int n;
    i_error_code  = 4'd3;
    i_error_valid = 1'b1;
    push_code(3, 2);
    n = 0;
    while (exp_q.size() > 0) begin
      step();
      i_error_valid = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL code3_pattern cycle %0d: got active/led=%b want %b", n, {o_error_active, o_led}, exp);
      end
      n++;
    end
  endtask

  // Continues the running code-3 pattern into its third period.
  task automatic test_gap_mask_clear();
    logic [1:0] exp;
    push_code(3, 1);
    // Keep only ON/OFF/ON/OFF/ON (40 cycles); the gap is checked below with stimulus.
    while (exp_q.size() > 40) void'(exp_q.pop_back());
    for (int i = 0; i < 40; i++) begin
      step();
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL pre_gap cycle %0d: got active/led=%b want %b", i, {o_error_active, o_led}, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      i_activity = (i == 0) ? 4'b1111 : ((i == 3) ? 4'b0001 : 4'b0000);
      exp_q.push_back(2'b10);
      step();
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL gap_masked cycle %0d: got active/led=%b want %b", i, {o_error_active, o_led}, exp);
      end
    end
    i_activity    = 4'b0000;
    i_error_clear = 1'b1;
    exp_q.push_back(2'b01);
    step();
    i_error_clear = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if ({o_error_active, o_led} !== exp) begin
      miscompares++;
      $display("FAIL clear_to_activity: got active/led=%b want %b", {o_error_active, o_led}, exp);
    end
    repeat (12) step();
    exp_q.push_back(2'b00);
    exp = exp_q.pop_front();
    vectors++;
    if ({o_error_active, o_led} !== exp) begin
      miscompares++;
      $display("FAIL clear_settle: got active/led=%b want %b", {o_error_active, o_led}, exp);
    end
  endtask

  task automatic test_clear_priority();
    logic [1:0] exp;
    i_error_code  = 4'd5;
    i_error_valid = 1'b1;
    i_error_clear = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(2'b00);
    for (int i = 0; i < 20; i++) begin
      step();
      i_error_valid = 1'b0;
      i_error_clear = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL clear_wins cycle %0d: got active/led=%b want %b", i, {o_error_active, o_led}, exp);
      end
    end
    i_error_code  = 4'd5;
    i_error_valid = 1'b1;
    exp_q.push_back(2'b11);
    step();
    exp = exp_q.pop_front();
    vectors++;
    if ({o_error_active, o_led} !== exp) begin
      miscompares++;
      $display("FAIL load5: got active/led=%b want %b", {o_error_active, o_led}, exp);
    end
    i_error_code = 4'd0;
    exp_q.push_back(2'b00);
    step();
    i_error_valid = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if ({o_error_active, o_led} !== exp) begin
      miscompares++;
      $display("FAIL code0_clear: got active/led=%b want %b", {o_error_active, o_led}, exp);
    end
  endtask

  task automatic test_restart_mid_off();
    logic [1:0] exp;
    int n;
    i_error_code  = 4'd3;
    i_error_valid = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(2'b11);
    for (int i = 0; i < 2; i++) exp_q.push_back(2'b10);
    n = 0;
    while (exp_q.size() > 0) begin
      step();
      i_error_valid = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL code3_before_reload cycle %0d: got active/led=%b want %b", n, {o_error_active, o_led}, exp);
      end
      n++;
    end
    i_error_code  = 4'd2;
    i_error_valid = 1'b1;
    push_code(2, 2);
    n = 0;
    while (exp_q.size() > 0) begin
      step();
      i_error_valid = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL code2_restart cycle %0d: got active/led=%b want %b", n, {o_error_active, o_led}, exp);
      end
      n++;
    end
    i_error_clear = 1'b1;
    step();
    i_error_clear = 1'b0;
  endtask

  task automatic test_override();
    logic [1:0] exp;
    logic       ovr;
`ifdef CART_LED_OVERRIDE_EN
    ovr = 1'b1;
`else
    ovr = 1'b0;
`endif
    i_error_code  = 4'd2;
    i_error_valid = 1'b1;
    push_code(2, 1);
    for (int i = 0; i < 40; i++) begin
      i_override_en    = 1'b0;
      i_override_value = 1'b0;
      if ((i >= 10 && i <= 13) || (i >= 28 && i <= 29)) begin
        i_override_en    = 1'b1;
        i_override_value = 1'b1;
      end else if (i >= 17 && i <= 19) begin
        i_override_en    = 1'b1;
        i_override_value = 1'b0;
      end
      step();
      i_error_valid = 1'b0;
      exp = exp_q.pop_front();
      if (ovr && i_override_en) exp[0] = i_override_value;
      vectors++;
      if ({o_error_active, o_led} !== exp) begin
        miscompares++;
        $display("FAIL override cycle %0d: got active/led=%b want %b", i, {o_error_active, o_led}, exp);
      end
    end
    i_override_en    = 1'b0;
    i_override_value = 1'b0;
    i_error_clear    = 1'b1;
    step();
    i_error_clear = 1'b0;
    vectors++;
    if (o_error_active !== 1'b0) begin
      miscompares++;
      $display("FAIL final_clear: got active=%b want 0", o_error_active);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    i_reset          = 1'b1;
    i_activity       = 4'b0000;
    i_error_valid    = 1'b0;
    i_error_code     = 4'd0;
    i_error_clear    = 1'b0;
    i_override_en    = 1'b0;
    i_override_value = 1'b0;
    test_reset();
    test_activity();
    test_error_pattern();
    test_gap_mask_clear();
    test_clear_priority();
    test_restart_mid_off();
    test_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
